// File: rtl/gb_mem_pkg.sv
// Shared memory-map constants and DMA state type for the OAM DMA engine.
package gb_mem_pkg;

  localparam logic [15:0] ADDR_DMA_REG = 16'hFF46;
  localparam int          OAM_SIZE     = 160;
  localparam logic [15:0] WRAM_BASE    = 16'hC000;
  localparam logic [15:0] ECHO_BASE    = 16'hE000;

  typedef enum logic [1:0] {IDLE, START, XFER} dma_state_t;

  // Echo RAM differs from WRAM only in one high address bit; clearing it folds the page back.
  function automatic logic [7:0] fold_src_hi(input logic [7:0] v);
    logic [7:0] echo_bit;
    echo_bit = ECHO_BASE[15:8] ^ WRAM_BASE[15:8];
    return (v >= ECHO_BASE[15:8]) ? (v & ~echo_bit) : v;
  endfunction

endpackage

// File: rtl/oam_dma_ctrl_if.sv
// CPU-side trigger bus, source-memory bus and OAM write port of the OAM DMA engine.
interface oam_dma_ctrl_if;

  logic [15:0] cpu_address_bus;
  logic        cpu_nread;
  logic        cpu_nwrite;
  logic        dma_active;
  logic [15:0] dma_address_bus;
  logic [7:0]  dma_data_in;
  logic        dma_nread;
  logic        dma_nsel_wram;
  logic [7:0]  oam_address;
  logic [7:0]  oam_data;
  logic        oam_nwrite;

  modport master (
    input  cpu_address_bus, cpu_nread, cpu_nwrite, dma_data_in,
    output dma_active, dma_address_bus, dma_nread, dma_nsel_wram,
           oam_address, oam_data, oam_nwrite
  );

  modport slave (
    output cpu_address_bus, cpu_nread, cpu_nwrite, dma_data_in,
    input  dma_active, dma_address_bus, dma_nread, dma_nsel_wram,
           oam_address, oam_data, oam_nwrite
  );

endinterface

// File: rtl/dma_slot_timer.sv
// Byte-slot divider: div runs 0..CYCLES_PER_BYTE-1 while i_run, with phase pulses.
module dma_slot_timer #(
  parameter int CYCLES_PER_BYTE = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_run,
  output logic o_slot_start,
  output logic o_slot_write,
  output logic o_slot_end
);

  localparam int                DIV_W    = $clog2(CYCLES_PER_BYTE);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CYCLES_PER_BYTE - 1);

  logic [DIV_W-1:0] r_div;

  always_ff @(posedge clock) begin
    if (reset || i_clear || !i_run) begin
      r_div <= '0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign o_slot_start = i_run && (r_div == '0);
  assign o_slot_write = i_run && (r_div == DIV_W'(1));
  assign o_slot_end   = i_run && (r_div == DIV_LAST);

endmodule

// File: rtl/oam_dma_ctrl.sv
// OAM DMA engine (FF46): copies DMA_LEN bytes from {src_hi,8'h00} into OAM.
// Optional build macro OAM_DMA_READBACK_EN makes FF46 readable on cpu_data_bus.
module oam_dma_ctrl
  import gb_mem_pkg::*;
#(
  parameter int CYCLES_PER_BYTE = 4,
  parameter int DMA_LEN         = OAM_SIZE,
  parameter int START_DELAY     = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  inout  wire  [7:0]            cpu_data_bus,
  oam_dma_ctrl_if.master        bus
);

  localparam logic [7:0] IDX_LAST   = 8'(DMA_LEN - 1);
  localparam logic [7:0] START_LAST = 8'((START_DELAY > 0) ? START_DELAY - 1 : 0);

  dma_state_t  r_state;
  logic [7:0]  r_idx;
  logic [7:0]  r_start_cnt;
  logic [7:0]  r_src_hi;
  logic [7:0]  r_data_q;
  logic        r_active;
  logic [15:0] r_dma_addr;
  logic        r_dma_nread;
  logic        r_dma_nsel;
  logic [7:0]  r_oam_addr;
  logic        r_oam_nwrite;

  logic w_trigger;
  logic w_slot_start;
  logic w_slot_write;
  logic w_slot_end;

  assign w_trigger = !bus.cpu_nwrite && (bus.cpu_address_bus == ADDR_DMA_REG);

  dma_slot_timer #(.CYCLES_PER_BYTE(CYCLES_PER_BYTE)) u_slot_timer (
    .clock        (clock),
    .reset        (reset),
    .i_clear      (w_trigger),
    .i_run        (r_state != IDLE),
    .o_slot_start (w_slot_start),
    .o_slot_write (w_slot_write),
    .o_slot_end   (w_slot_end)
  );

  // Strobes default high every clock; a trigger therefore cancels any byte in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_start_cnt  <= '0;
      r_src_hi     <= '0;
      r_data_q     <= '0;
      r_active     <= 1'b0;
      r_dma_addr   <= '0;
      r_dma_nread  <= 1'b1;
      r_dma_nsel   <= 1'b1;
      r_oam_addr   <= '0;
      r_oam_nwrite <= 1'b1;
    end else begin
      r_dma_nread  <= 1'b1;
      r_dma_nsel   <= 1'b1;
      r_oam_nwrite <= 1'b1;
      if (w_trigger) begin
        r_src_hi    <= fold_src_hi(cpu_data_bus);
        r_state     <= (START_DELAY == 0) ? XFER : START;
        r_idx       <= '0;
        r_start_cnt <= '0;
        r_active    <= 1'b1;
      end else begin
        case (r_state)
          IDLE: r_active <= 1'b0;
          START: begin
            if (w_slot_end) begin
              if (r_start_cnt == START_LAST) r_state <= XFER;
              else                           r_start_cnt <= r_start_cnt + 8'd1;
            end
          end
          XFER: begin
            if (w_slot_start) begin
              r_dma_nread <= 1'b0;
              r_dma_nsel  <= 1'b0;
              r_dma_addr  <= {r_src_hi, 8'h00} + {8'h00, r_idx};
            end
            if (w_slot_write) begin
              r_data_q     <= bus.dma_data_in;
              r_oam_addr   <= r_idx;
              r_oam_nwrite <= 1'b0;
            end
            if (w_slot_end) begin
              r_idx <= r_idx + 8'd1;
              if (r_idx == IDX_LAST) r_state <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.dma_active      = r_active;
  assign bus.dma_address_bus = r_dma_addr;
  assign bus.dma_nread       = r_dma_nread;
  assign bus.dma_nsel_wram   = r_dma_nsel;
  assign bus.oam_address     = r_oam_addr;
  assign bus.oam_data        = r_data_q;
  assign bus.oam_nwrite      = r_oam_nwrite;

`ifdef OAM_DMA_READBACK_EN
  logic [7:0] r_v;

  always_ff @(posedge clock) begin
    if (reset)          r_v <= '0;
    else if (w_trigger) r_v <= cpu_data_bus;
  end

  assign cpu_data_bus = (!bus.cpu_nread && (bus.cpu_address_bus == ADDR_DMA_REG)) ? r_v : 8'bz;
`else
  logic w_unused_nread;
  assign w_unused_nread = bus.cpu_nread;
  assign cpu_data_bus   = 8'bz;
`endif

endmodule
